// File: rtl/cnu_layer_sched_pkg.sv
// cnu_layer_sched_pkg: FSM encoding and default sizing shared by the CNU layer scheduler
package cnu_layer_sched_pkg;
  typedef enum logic [2:0] {
    IDLE = 3'd0,
    RD   = 3'd1,
    LOAD = 3'd2,
    WAIT = 3'd3,
    WB   = 3'd4,
    NEXT = 3'd5,
    FIN  = 3'd6
  } sched_state_t;
  localparam int DEF_NUM_LAYERS = 12;
  localparam int DEF_LAYER_AW = 4;
  localparam int DEF_MAX_ITER = 8;
  localparam int DEF_ITER_W = 4;
  localparam int DEF_TIMEOUT = 63;
  localparam int CNU_LAT = 34;
endpackage

// File: rtl/cnu_watchdog.sv
// cnu_watchdog: clearable cycle counter flagging the enabled cycle on which it reaches TIMEOUT
module cnu_watchdog #(
  parameter int TIMEOUT = 63,
  parameter int W = $clog2(TIMEOUT + 1)
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clr,
  input  logic         en,
  output logic [W-1:0] count,
  output logic         expire
);
  always_ff @(posedge clk)
    if (rst || clr) count <= '0;
    else if (en) count <= count + 1'b1;
  assign expire = en && count == W'(TIMEOUT - 1);
endmodule

// File: rtl/cnu_layer_sched.sv
// cnu_layer_sched: per-layer read/load/wait/write-back sequencer for the layered QC-LDPC decoder; CNU_SCHED_EARLY_TERM_EN enables syndrome early termination
module cnu_layer_sched
  import cnu_layer_sched_pkg::*;
#(
  parameter int NUM_LAYERS = DEF_NUM_LAYERS,
  parameter int LAYER_AW = DEF_LAYER_AW,
  parameter int MAX_ITER = DEF_MAX_ITER,
  parameter int ITER_W = DEF_ITER_W,
  parameter int TIMEOUT = DEF_TIMEOUT
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  input  logic                storage,
  input  logic                synd_ok,
  output logic                load_to_CNU,
  output logic                mem_rd_en,
  output logic [LAYER_AW-1:0] rd_layer,
  output logic                mem_wr_en,
  output logic [LAYER_AW-1:0] wr_layer,
  output logic [ITER_W-1:0]   iter_cnt,
  output logic                busy,
  output logic                done,
  output logic                err
);
  localparam int WD_W = $clog2(TIMEOUT + 1);
  sched_state_t state, state_nxt;
  logic [LAYER_AW-1:0] layer, layer_nxt;
  logic [ITER_W-1:0] iter_nxt;
  logic [WD_W-1:0] unused_wd_count;
  logic wd_expire, spurious, last, early, accept;
`ifdef CNU_SCHED_EARLY_TERM_EN
  assign early = synd_ok;
`else
  logic unused_synd_ok;
  assign unused_synd_ok = synd_ok;
  assign early = 1'b0;
`endif
  cnu_watchdog #(.TIMEOUT(TIMEOUT), .W(WD_W)) u_wd (
    .clk(clk),
    .rst(rst),
    .clr(state == LOAD),
    .en(state == WAIT),
    .count(unused_wd_count),
    .expire(wd_expire)
  );
  assign busy = state != IDLE;
  assign mem_rd_en = state == RD;
  assign load_to_CNU = state == LOAD;
  assign mem_wr_en = state == WB;
  assign done = state == FIN;
  assign accept = state == IDLE && start;
  assign spurious = storage && state != WAIT;
  assign last = layer == LAYER_AW'(NUM_LAYERS - 1);
  assign iter_nxt = iter_cnt + 1'b1;
  always_comb begin
    state_nxt = state;
    layer_nxt = layer;
    case (state)
      IDLE: if (start) begin
        state_nxt = RD;
        layer_nxt = '0;
      end
      RD:   state_nxt = LOAD;
      LOAD: state_nxt = WAIT;
      WAIT: state_nxt = storage ? WB : wd_expire ? FIN : WAIT;
      WB:   state_nxt = NEXT;
      NEXT: begin
        layer_nxt = last ? '0 : layer + 1'b1;
        state_nxt = last && (iter_nxt == ITER_W'(MAX_ITER) || early) ? FIN : RD;
      end
      FIN:  state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
    // a stray CNU result aborts an active decode; FIN already terminates on its own
    if (spurious && state != IDLE && state != FIN) state_nxt = FIN;
  end
  always_ff @(posedge clk)
    if (rst) begin
      state <= IDLE;
      layer <= '0;
      rd_layer <= '0;
      wr_layer <= '0;
      iter_cnt <= '0;
      err <= 1'b0;
    end else begin
      state <= state_nxt;
      layer <= layer_nxt;
      if (state_nxt == RD) rd_layer <= layer_nxt;
      if (state_nxt == WB) wr_layer <= layer;
      if (accept) iter_cnt <= '0;
      else if (state == NEXT && last) iter_cnt <= iter_nxt;
      if (accept) err <= 1'b0;
      else if (spurious || (state == WAIT && !storage && wd_expire)) err <= 1'b1;
    end
endmodule
